// File: rtl/rr_arb8_ctrl_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package rr_arb8_ctrl_pkg;

  localparam int NUM_REQ          = 8;
  localparam int ID_W             = 3;
  localparam int DEF_MAX_HOLD     = 16;
  localparam int DEF_RESET_LAST   = 7;
  localparam int HOLD_W           = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] onehot8(input logic [ID_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arb8_ctrl_pick.sv
// Combinational round-robin search: first eligible index after 'last', wrapping mod 8.
module rr_pick8
  import rr_arb8_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [ID_W-1:0]    last,
  output logic               found,
  output logic [ID_W-1:0]    winner
);

  logic [ID_W-1:0]      start;
  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;
  logic [ID_W-1:0]      offset;

  // Rotating right by 'start' puts the highest-priority candidate at bit 0.
  assign start   = last + ID_W'(1);
  assign doubled = {eligible, eligible} >> start;
  assign rotated = doubled[NUM_REQ-1:0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found  = 1'b1;
        offset = ID_W'(i);
      end
    end
  end

  assign winner = start + offset;

endmodule

// File: rtl/rr_arb8_ctrl.sv
// Round-robin arbiter for one shared resource among 8 requesters, one dead cycle per handover.
// Optional forced release after MAX_HOLD cycles is enabled with `define ARB_TIMEOUT_EN.
module rr_arb8_ctrl
  import rr_arb8_ctrl_pkg::*;
#(
  parameter int RESET_LAST = DEF_RESET_LAST,
  parameter int MAX_HOLD   = DEF_MAX_HOLD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_req,
  output logic               timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arb8_ctrl: MAX_HOLD must be in 2..255");
  end

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               valid_q, valid_d;
  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [ID_W-1:0]    winner;
  logic               owner_req;

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic               timeout_q, timeout_d;

  assign eligible = req & ~mask_q;
  assign timeout  = timeout_q;
`else
  assign eligible = req;
  assign timeout  = 1'b0;
`endif

  assign any_req   = |req;
  assign owner_req = req[grant_id_q];

  rr_pick8 u_pick (
    .eligible (eligible),
    .last     (last_q),
    .found    (found),
    .winner   (winner)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    valid_d    = valid_q;
`ifdef ARB_TIMEOUT_EN
    hold_d     = hold_q;
    timeout_d  = 1'b0;
    // A mask bit lives only until its requester lets go once.
    mask_d     = mask_q & req;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d    = ST_OWNED;
          grant_d    = onehot8(winner);
          grant_id_d = winner;
          valid_d    = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_d     = '0;
`endif
        end
      end
      ST_OWNED: begin
        if (!owner_req) begin
          state_d    = ST_IDLE;
          last_d     = grant_id_q;
          grant_d    = '0;
          grant_id_d = '0;
          valid_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        end else if (hold_q == HOLD_LAST) begin
          state_d            = ST_IDLE;
          last_d             = grant_id_q;
          grant_d            = '0;
          grant_id_d         = '0;
          valid_d            = 1'b0;
          timeout_d          = 1'b1;
          mask_d[grant_id_q] = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= ID_W'(RESET_LAST);
      grant_q    <= '0;
      grant_id_q <= '0;
      valid_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q     <= '0;
      mask_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      valid_q    <= valid_d;
`ifdef ARB_TIMEOUT_EN
      hold_q     <= hold_d;
      mask_q     <= mask_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = valid_q;

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Directed, table-driven bench for rr_arb8_ctrl; timeout section follows ARB_TIMEOUT_EN.
module tb_rr_arb8_ctrl;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_MAX_HOLD = 4;
`else
  localparam int TB_MAX_HOLD = 16;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] grant;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic       any_req;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] id;
    logic       any;
  } vec_t;

  vec_t vecs[$];

  rr_arb8_ctrl #(
    .RESET_LAST (7),
    .MAX_HOLD   (TB_MAX_HOLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .any_req     (any_req),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic [7:0] q);
    reset = r;
    req   = q;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] id,
                            input logic any, input logic to);
    check({tag, ".grant"},       32'(grant),       32'(g));
    check({tag, ".grant_valid"}, 32'(grant_valid), 32'(|g));
    check({tag, ".grant_id"},    32'(grant_id),    32'(id));
    check({tag, ".any_req"},     32'(any_req),     32'(any));
    check({tag, ".timeout"},     32'(timeout),     32'(to));
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].rst, vecs[i].req);
      expect_out($sformatf("%s[%0d]", tag, i), vecs[i].grant, vecs[i].id, vecs[i].any, 1'b0);
    end
    vecs.delete();
  endtask

  initial begin
    logic [7:0] oh;
    reset = 1'b1;
    req   = 8'h00;

    // Reset, idle, basic grant, release with dead cycle before requester 7.
    vecs.push_back('{1'b1, 8'h00, 8'h00, 3'd0, 1'b0});
    for (int i = 0; i < 5; i++) vecs.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 8'h81, 8'h01, 3'd0, 1'b1});
    for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 8'h81, 8'h01, 3'd0, 1'b1});
    vecs.push_back('{1'b0, 8'h80, 8'h00, 3'd0, 1'b1});
    vecs.push_back('{1'b0, 8'h80, 8'h80, 3'd7, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0});
    run_table("basic");

    // All requesting: each owner holds 2 cycles, drops for one, order 0..7 then 0.
    for (int i = 0; i < 9; i++) begin
      oh = 8'h01 << (i % 8);
      tick(1'b0, 8'hFF);
      expect_out($sformatf("rr%0d.a", i), oh, 3'(i % 8), 1'b1, 1'b0);
      tick(1'b0, 8'hFF);
      expect_out($sformatf("rr%0d.b", i), oh, 3'(i % 8), 1'b1, 1'b0);
      tick(1'b0, 8'hFF & ~oh);
      expect_out($sformatf("rr%0d.dead", i), 8'h00, 3'd0, 1'b1, 1'b0);
    end
    tick(1'b0, 8'h00);
    expect_out("rr.end", 8'h00, 3'd0, 1'b0, 1'b0);

    // Mid-ownership reset, then pointer back at RESET_LAST; also wrap past 7.
    vecs.push_back('{1'b0, 8'h08, 8'h08, 3'd3, 1'b1});
    vecs.push_back('{1'b0, 8'h28, 8'h08, 3'd3, 1'b1});
    vecs.push_back('{1'b1, 8'h28, 8'h00, 3'd0, 1'b1});
    vecs.push_back('{1'b0, 8'h28, 8'h08, 3'd3, 1'b1});
    vecs.push_back('{1'b0, 8'h20, 8'h00, 3'd0, 1'b1});
    vecs.push_back('{1'b0, 8'h20, 8'h20, 3'd5, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 8'h11, 8'h01, 3'd0, 1'b1});
    vecs.push_back('{1'b0, 8'h10, 8'h00, 3'd0, 1'b1});
    vecs.push_back('{1'b0, 8'h10, 8'h10, 3'd4, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0});
    run_table("rst");

`ifdef ARB_TIMEOUT_EN
    // Held request: 4 grant cycles, one timeout pulse, then masked until req drops.
    for (int c = 0; c < TB_MAX_HOLD; c++) begin
      tick(1'b0, 8'h04);
      expect_out($sformatf("to.hold%0d", c), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    tick(1'b0, 8'h04);
    expect_out("to.pulse", 8'h00, 3'd0, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 8'h04);
      expect_out($sformatf("to.masked%0d", c), 8'h00, 3'd0, 1'b1, 1'b0);
    end
    tick(1'b0, 8'h00);
    expect_out("to.drop", 8'h00, 3'd0, 1'b0, 1'b0);
    tick(1'b0, 8'h04);
    expect_out("to.regrant", 8'h04, 3'd2, 1'b1, 1'b0);
    tick(1'b0, 8'h00);
    expect_out("to.release", 8'h00, 3'd0, 1'b0, 1'b0);
`else
    // Without the timeout feature a held request keeps the grant indefinitely.
    for (int c = 0; c < 300; c++) begin
      tick(1'b0, 8'h04);
      expect_out($sformatf("hold%0d", c), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    tick(1'b0, 8'h00);
    expect_out("hold.release", 8'h00, 3'd0, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arb8_ctrl.md
Name: rr_arb8_ctrl

Overview:
- Round-robin arbiter and sequencer that shares one single-owner datapath resource (e.g. memory/bus port of the CPU) among 8 requesters.
- Uses an 8-way OR reduction of the request vector as its "any request pending" term.
- Issues a registered one-hot grant and holds it until the owner releases.
- Sits between the requesting units and the shared resource's mux select.

Parameters:
- RESET_LAST, 7: index treated as "last owner" after reset; the first search starts at RESET_LAST+1 mod 8, so requester 0 by default.
- MAX_HOLD, 16: maximum grant cycles before forced release; used only with ARB_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  8  request vector; bit i held high by requester i for the whole ownership
- grant  out  8  registered one-hot grant; all-zero when idle
- grant_valid  out  1  registered; equals OR of grant
- grant_id  out  3  registered binary index of owner; 0 when idle
- any_req  out  1  combinational OR of all 8 req bits
- timeout  out  1  registered one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high, sampled on the rising edge of `clk`.
- Reset values: grant=0, grant_valid=0, grant_id=0, timeout=0, state=IDLE, last=RESET_LAST, hold_cnt=0, mask=0.
- States: IDLE and OWNED.
- IDLE:
  - If (req & ~mask) != 0, pick the first set bit searching last+1, last+2, … wrapping mod 8.
  - Next edge: grant=onehot(winner), grant_id=winner, grant_valid=1, state=OWNED.
  - Latency: req seen at edge N gives grant registered at edge N+1.
  - If no unmasked request, stay in IDLE with outputs 0.
- OWNED:
  - While req[grant_id]=1, hold the grant. Other requests are ignored, with no preemption.
  - When req[grant_id]=0 at edge N: at N+1 clear grant/grant_valid/grant_id, set last=owner, go to IDLE.
  - A new winner is therefore granted at N+2 at the earliest. The mandatory one dead cycle lets the resource mux settle.
- Fairness: the requester just served has lowest priority next round. Wrap-around: last=7 means the search starts at 0.
- Re-request: an owner that drops req and re-raises it immediately competes normally, at lowest priority.
- Simultaneous release and new requests: handled via the dead cycle. No same-edge handover.
- Mid-operation reset: grant clears on that edge and the pointer returns to RESET_LAST regardless of state.
- any_req is purely combinational from req. It is not gated by mask or state.
- Glitch rule: grant, grant_valid and grant_id all come from flops. No combinational path from req to grant.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt resets to 0 on entering OWNED and increments each OWNED cycle.
  - If hold_cnt reaches MAX_HOLD-1 while req[owner] is still 1: next edge clears the grant, pulses timeout=1 for one cycle, sets last=owner, sets mask[owner]=1, and goes to IDLE.
  - mask[i] clears on the first cycle req[i]=0. A masked requester is not eligible.
  - Grant duration never exceeds MAX_HOLD cycles.
- Undefined: no counter and no mask logic; timeout is tied to 0; a grant is held indefinitely.

Decomposition:
- Shared package holds: NUM_REQ=8, ID_W=3, state encoding (ST_IDLE=0, ST_OWNED=1), and the default MAX_HOLD.
- One natural sub-module: rr_pick8, a combinational priority search.
  - Inputs: eligible[7:0], last[2:0].
  - Outputs: found, winner[2:0].
  - Implemented as a rotate, fixed-priority encode, then un-rotate.

Test Plan:
- Reset then req=8'h00 for 5 cycles: grant=0, grant_valid=0, any_req=0 throughout.
- req=8'h81 at cycle 1: grant=8'h01 at cycle 2. Drop req[0] at cycle 5: grant=0 at cycle 6, grant=8'h80 (id 7) at cycle 7.
- req=8'hFF held, each owner releasing after 2 cycles: grant order 0,1,…,7,0 with exactly one idle cycle between owners.
- Owner 3 holding, req[5] rises, then reset asserted for one cycle: grant=0 next edge. After reset, the search starts at 0 and grants 3 (req=8'h28) before 5.
- With ARB_TIMEOUT_EN and MAX_HOLD=4: req=8'h04 held. Grant lasts 4 cycles, then timeout=1 for one cycle and grant=0. No regrant to requester 2 until req[2] drops and re-rises.
- Without ARB_TIMEOUT_EN, same stimulus for 300 cycles: grant=8'h04 stays continuous, timeout never asserts.
